oci_trace_capture: RTL and testbench

Parametrised successor to the CPU OCI test-bench trace sink. It captures debug-core trace entries (dct_buffer plus dct_count) into an on-chip circular buffer while the test runs. It freezes capture on test_ending or test_has_ended, then lets a bench or debug master drain the entries through a 1-cycle-latency read port. Sits beside each cpuN OCI in the MPSoC simulation/debug fabric.

---
 rtl/oci_trace_capture.sv | 177 +++++++++++++++++
 tb/tb_oci_trace_capture.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oci_trace_capture.sv
// oci_trace_capture: trace sink for one cpu OCI. Captures debug-core trace entries
// into a circular buffer during the test. Capture freezes on test_ending or
// test_has_ended. The entries can then be drained through a read port with one
// cycle of latency.
//
// Optional build macro: OCI_TRACE_TIMESTAMP_EN. When it is defined, each entry also
// carries a 16-bit timestamp. The timestamp counts cycles spent in CAPTURE.
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   dct_buffer/count     trace payload; a nonzero count marks a valid entry
//   test_ending          stop capture (CAPTURE -> FROZEN)
//   test_has_ended       enter DRAIN
//   rd_en                read request, honoured in DRAIN only
//   rd_data/rd_valid     oldest entry {[ts,] count, buffer}, one-cycle valid pulse
//   level/empty/full     registered fill status
//   overflow/drop_count  sticky drop flag, saturating drop/overwrite counter
//   frozen/done          state indicators
module oci_trace_capture #(
   parameter int unsigned DATA_W    = 30,
   parameter int unsigned COUNT_W   = 4,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned WRAP_MODE = 0,
`ifdef OCI_TRACE_TIMESTAMP_EN
   localparam int unsigned TS_W     = 16,
`else
   localparam int unsigned TS_W     = 0,
`endif
   localparam int unsigned ENTRY_W  = COUNT_W + DATA_W + TS_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [DATA_W-1:0]  dct_buffer,
   input  logic [COUNT_W-1:0] dct_count,
   input  logic               test_ending,
   input  logic               test_has_ended,
   input  logic               rd_en,
   output logic [ENTRY_W-1:0] rd_data,
   output logic               rd_valid,
   output logic [ADDR_W:0]    level,
   output logic               empty,
   output logic               full,
   output logic               overflow,
   output logic [15:0]        drop_count,
   output logic               frozen,
   output logic               done
);

   localparam int unsigned LVL_W = ADDR_W + 1;

   typedef enum logic [1:0] {StCapture, StFrozen, StDrain, StDone} state_e;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic               empty_q, empty_d;
   logic               full_q, full_d;
   logic [ENTRY_W-1:0] rd_data_q, rd_data_d;
   logic               rd_valid_q, rd_valid_d;
   logic               overflow_q, overflow_d;
   logic [15:0]        drop_cnt_q, drop_cnt_d;
   logic               mem_we;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] mem_q [DEPTH];

`ifdef OCI_TRACE_TIMESTAMP_EN
   logic [15:0]        ts_q, ts_d;

   assign ts_d     = (state_q == StCapture) ? ts_q + 16'd1 : ts_q;
   assign wr_entry = {ts_q, dct_count, dct_buffer};
`else
   assign wr_entry = {dct_count, dct_buffer};
`endif

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      mem_we     = 1'b0;

      unique case (state_q)
         StCapture: begin
            if (dct_count != '0) begin
               if (!full_q) begin
                  mem_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                  level_d  = level_q + LVL_W'(1);
               end else begin
                  overflow_d = 1'b1;
                  if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
                  // Overwrite oldest: the write slot is the read slot, so both advance.
                  if (WRAP_MODE != 0) begin
                     mem_we   = 1'b1;
                     wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                     rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                  end
               end
            end
            if (test_has_ended)   state_d = StDrain;
            else if (test_ending) state_d = StFrozen;
         end
         StFrozen: begin
            if (test_has_ended) state_d = StDrain;
         end
         StDrain: begin
            if (rd_en && !empty_q) begin
               rd_data_d  = mem_q[rd_ptr_q];
               rd_valid_d = 1'b1;
               rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
               level_d    = level_q - LVL_W'(1);
            end else if (level_q == '0) begin
               state_d = StDone;
            end
         end
         StDone: ;
         default: state_d = StCapture;
      endcase

      empty_d = (level_d == '0);
      full_d  = (level_d == LVL_W'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StCapture;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
`ifdef OCI_TRACE_TIMESTAMP_EN
         ts_q       <= '0;
`endif
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
`ifdef OCI_TRACE_TIMESTAMP_EN
         ts_q       <= ts_d;
`endif
      end
   end

   // Buffer RAM is not reset; its contents only matter behind the level count.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_ptr_q] <= wr_entry;
   end

   assign rd_data    = rd_data_q;
   assign rd_valid   = rd_valid_q;
   assign level      = level_q;
   assign empty      = empty_q;
   assign full       = full_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_cnt_q;
   assign frozen     = (state_q != StCapture);
   assign done       = (state_q == StDone);

endmodule

// File: tb/tb_oci_trace_capture.sv
module tb_oci_trace_capture;

   localparam int DATA_W  = 30;
   localparam int COUNT_W = 4;
   localparam int DEPTH   = 16;
   localparam int ADDR_W  = 4;
`ifdef OCI_TRACE_TIMESTAMP_EN
   localparam int TS_W = 16;
`else
   localparam int TS_W = 0;
`endif
   localparam int EW = COUNT_W + DATA_W + TS_W;

   typedef enum int {PCap, PFrz, PDrn, PDone} phase_e;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic [DATA_W-1:0]  dct_buffer = '0;
   logic [COUNT_W-1:0] dct_count = '0;
   logic               test_ending = 1'b0;
   logic               test_has_ended = 1'b0;
   logic               rd_en = 1'b0;

   logic [EW-1:0] rd_data0, rd_data1;
   logic          rd_valid0, rd_valid1;
   logic [ADDR_W:0] level0, level1;
   logic          empty0, empty1, full0, full1, ovf0, ovf1;
   logic [15:0]   drop0, drop1;
   logic          frozen0, frozen1, done0, done1;

   int n_chk = 0;
   int n_fail = 0;
   bit mon_en = 1'b0;

   // Reference model: per buffer mode, an ordered list with the oldest entry at index 0.
   logic [EW-1:0] mb [2][DEPTH];
   int            mcnt [2];
   int            mdrop [2];
   phase_e        ph;
   logic [15:0]   mts;
   logic [EW-1:0] exp0 [$];
   logic [EW-1:0] exp1 [$];

   always #5 clk = ~clk;

   oci_trace_capture #(.DATA_W(DATA_W), .COUNT_W(COUNT_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
                       .WRAP_MODE(0)) u_stop (
      .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
      .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_en(rd_en),
      .rd_data(rd_data0), .rd_valid(rd_valid0), .level(level0), .empty(empty0),
      .full(full0), .overflow(ovf0), .drop_count(drop0), .frozen(frozen0), .done(done0));

   oci_trace_capture #(.DATA_W(DATA_W), .COUNT_W(COUNT_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
                       .WRAP_MODE(1)) u_wrap (
      .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
      .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_en(rd_en),
      .rd_data(rd_data1), .rd_valid(rd_valid1), .level(level1), .empty(empty1),
      .full(full1), .overflow(ovf1), .drop_count(drop1), .frozen(frozen1), .done(done1));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: every read-data pulse is matched against the scoreboard queues.
   always @(negedge clk) begin
      logic [EW-1:0] ed;
      if (mon_en) begin
         n_chk++;
         if (rd_valid0 !== (exp0.size() != 0)) begin
            n_fail++;
            $display("FAIL rd_valid_stop: got %b expected %b at %0t", rd_valid0,
                     exp0.size() != 0, $time);
         end
         if (rd_valid0 === 1'b1 && exp0.size() != 0) begin
            ed = exp0.pop_front();
            n_chk++;
            if (rd_data0 !== ed) begin
               n_fail++;
               $display("FAIL rd_data_stop: got 0x%0h expected 0x%0h at %0t", rd_data0, ed,
                        $time);
            end
         end
         n_chk++;
         if (rd_valid1 !== (exp1.size() != 0)) begin
            n_fail++;
            $display("FAIL rd_valid_wrap: got %b expected %b at %0t", rd_valid1,
                     exp1.size() != 0, $time);
         end
         if (rd_valid1 === 1'b1 && exp1.size() != 0) begin
            ed = exp1.pop_front();
            n_chk++;
            if (rd_data1 !== ed) begin
               n_fail++;
               $display("FAIL rd_data_wrap: got 0x%0h expected 0x%0h at %0t", rd_data1, ed,
                        $time);
            end
         end
      end
   end

   task automatic chk_status();
      int dsat [2];
      for (int m = 0; m < 2; m++) dsat[m] = (mdrop[m] > 65535) ? 65535 : mdrop[m];
      chk("level_stop",  64'(level0),  64'(mcnt[0]));
      chk("level_wrap",  64'(level1),  64'(mcnt[1]));
      chk("empty_stop",  64'(empty0),  64'(mcnt[0] == 0));
      chk("empty_wrap",  64'(empty1),  64'(mcnt[1] == 0));
      chk("full_stop",   64'(full0),   64'(mcnt[0] == DEPTH));
      chk("full_wrap",   64'(full1),   64'(mcnt[1] == DEPTH));
      chk("ovf_stop",    64'(ovf0),    64'(mdrop[0] > 0));
      chk("ovf_wrap",    64'(ovf1),    64'(mdrop[1] > 0));
      chk("drops_stop",  64'(drop0),   64'(dsat[0]));
      chk("drops_wrap",  64'(drop1),   64'(dsat[1]));
      chk("frozen_stop", 64'(frozen0), 64'(ph != PCap));
      chk("frozen_wrap", 64'(frozen1), 64'(ph != PCap));
      chk("done_stop",   64'(done0),   64'(ph == PDone));
      chk("done_wrap",   64'(done1),   64'(ph == PDone));
   endtask

   // One clock cycle: drive the inputs, advance the model, clock the DUT, then check it.
   task automatic cyc(input logic [DATA_W-1:0] d, input logic [COUNT_W-1:0] c,
                      input logic te, input logic the, input logic rd, input logic rst);
      logic [EW-1:0] e;
      logic [EW-1:0] got [2];
      bit acc;
      acc = 1'b0;
      reset = rst; dct_buffer = d; dct_count = c;
      test_ending = te; test_has_ended = the; rd_en = rd;
`ifdef OCI_TRACE_TIMESTAMP_EN
      e = {mts, c, d};
`else
      e = {c, d};
`endif
      if (!rst) begin
         case (ph)
            PCap: begin
               if (c != 0) begin
                  for (int m = 0; m < 2; m++) begin
                     if (mcnt[m] < DEPTH) begin
                        mb[m][mcnt[m]] = e;
                        mcnt[m]++;
                     end else begin
                        mdrop[m]++;
                        if (m == 1) begin
                           for (int i = 0; i < DEPTH - 1; i++) mb[m][i] = mb[m][i+1];
                           mb[m][DEPTH-1] = e;
                        end
                     end
                  end
               end
               mts = mts + 16'd1;
               if (the)     ph = PDrn;
               else if (te) ph = PFrz;
            end
            PFrz: if (the) ph = PDrn;
            PDrn: begin
               if (rd && mcnt[0] > 0) begin
                  acc = 1'b1;
                  for (int m = 0; m < 2; m++) begin
                     got[m] = mb[m][0];
                     for (int i = 0; i < DEPTH - 1; i++) mb[m][i] = mb[m][i+1];
                     mcnt[m]--;
                  end
               end else if (mcnt[0] == 0) begin
                  ph = PDone;
               end
            end
            default: ;
         endcase
      end
      @(posedge clk);
      #1;
      if (rst) begin
         for (int m = 0; m < 2; m++) begin
            mcnt[m] = 0;
            mdrop[m] = 0;
         end
         ph = PCap;
         mts = '0;
      end
      if (acc) begin
         exp0.push_back(got[0]);
         exp1.push_back(got[1]);
      end
      chk_status();
   endtask

   task automatic idle(); cyc('0, '0, 1'b0, 1'b0, 1'b0, 1'b0); endtask
   task automatic wr(input logic [DATA_W-1:0] d); cyc(d, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0); endtask
   task automatic rd(); cyc('0, '0, 1'b0, 1'b0, 1'b1, 1'b0); endtask
   task automatic rst(); cyc('0, '0, 1'b0, 1'b0, 1'b0, 1'b1); endtask

   initial begin
      ph = PCap;
      mts = '0;
      for (int m = 0; m < 2; m++) begin
         mcnt[m] = 0;
         mdrop[m] = 0;
      end
      @(posedge clk);
      #1;
      rst();
      mon_en = 1'b1;
      chk("reset_rd_data", 64'(rd_data0), 64'd0);

      // Basic order through a full capture / freeze / drain / done cycle.
      wr(30'h1); wr(30'h2); wr(30'h3);
      cyc('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc('0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      rd(); rd(); rd();
      idle(); idle();
      chk("basic_done", 64'(done0), 64'd1);

      // 20 writes into 16 slots: stop-when-full keeps 1..16, wrap keeps 5..20.
      rst();
      for (int i = 1; i <= 20; i++) wr(DATA_W'(i));
      chk("fill_drops", 64'(drop0), 64'd4);
      chk("fill_level", 64'(level1), 64'd16);
      cyc('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc('0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 18; i++) rd();
      idle();

      // Freeze edge: the write alongside test_ending lands, the next one does not.
      rst();
      cyc(30'hA, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(30'hB, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("freeze_level", 64'(level0), 64'd1);
      cyc('0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      rd(); rd(); rd();
      idle();

      // Gating: reads in CAPTURE are ignored, zero-count entries are never stored.
      rst();
      cyc(30'h5, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(30'h7, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(30'h9, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(30'hC, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      rd(); rd(); rd(); rd();

      // Randomised rounds.
      for (int r = 0; r < 8; r++) begin
         int n;
         rst();
         n = $urandom_range(40, 5);
         for (int i = 0; i < n; i++) begin
            logic [COUNT_W-1:0] c;
            c = ($urandom_range(3, 0) == 0) ? '0 : COUNT_W'($urandom);
            cyc(DATA_W'($urandom), c, ($urandom_range(15, 0) == 0), 1'b0,
                1'($urandom), 1'b0);
         end
         cyc(DATA_W'($urandom), COUNT_W'($urandom), 1'b1, 1'($urandom), 1'b0, 1'b0);
         for (int i = 0; i < int'($urandom_range(3, 0)); i++)
            cyc(DATA_W'($urandom), 4'd1, 1'b0, 1'b0, 1'($urandom), 1'b0);
         cyc('0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
         for (int i = 0; i < 25; i++)
            cyc('0, '0, 1'b0, 1'b0, ($urandom_range(3, 0) != 0), 1'b0);
      end

      // Reset in the middle of a drain, then back-to-back writes for the timestamp.
      rst();
      for (int i = 1; i <= 5; i++) wr(DATA_W'(16 + i));
      cyc('0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      rd(); rd();
      cyc('0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("midrst_rd_valid", 64'(rd_valid0), 64'd0);
      wr(30'h55); wr(30'h66);
      cyc('0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      rd(); rd();
      idle(); idle();

      chk("scoreboard_stop_drained", 64'(exp0.size()), 64'd0);
      chk("scoreboard_wrap_drained", 64'(exp1.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
